intdiv_seq_ctrl: RTL and testbench



---
 rtl/intdiv_pkg.sv | 28 ++
 rtl/intdiv_intdiv.sv | 30 +++
 rtl/intdiv_seq_ctrl.sv | 141 ++++++++++++++
 tb/tb_intdiv_seq_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/intdiv_pkg.sv
// ============================================================================
// Module      : intdiv_pkg
// Description : Shared types and helpers for the sequential divider stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package intdiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DONE   = 2'd2
    } div_state_t;

    typedef struct packed {
        logic dz;
        logic ovf;
    } div_flags_t;

    // Bit pattern of -2^(n-1); callers truncate to n bits.
    function automatic logic [63:0] most_neg(input int n);
        return 64'(1) << (n - 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/intdiv_intdiv.sv
// ============================================================================
// Module      : intdiv_intdiv
// Description : Combinational signed divider, quotient truncated toward zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module intdiv_intdiv #(
    parameter int N = 5
) (
    input  logic [N-1:0] i_x,
    input  logic [N-1:0] i_y,
    output logic [N-1:0] o_q
);

    logic [N-1:0] w_ax;
    logic [N-1:0] w_ay;
    logic [N-1:0] w_aq;

    // Magnitudes fit in N unsigned bits, including |-2^(N-1)|.
    always_comb begin
        w_ax = i_x[N-1] ? (~i_x + 1'b1) : i_x;
        w_ay = i_y[N-1] ? (~i_y + 1'b1) : i_y;
        w_aq = (w_ay == '0) ? '0 : (w_ax / w_ay);
        o_q  = (i_x[N-1] ^ i_y[N-1]) ? (~w_aq + 1'b1) : w_aq;
    end

endmodule

`default_nettype wire

// File: rtl/intdiv_seq_ctrl.sv
// ============================================================================
// Module      : intdiv_seq_ctrl
// Description : Issue/capture stage around intdiv_intdiv with multicycle settle.
//               Optional macro INTDIV_SPECIAL_EN adds divide-by-zero/overflow
//               detection with a fast path that bypasses settling.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module intdiv_seq_ctrl
    import intdiv_pkg::*;
#(
    parameter int N             = 5,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_flush,
    input  logic         i_in_valid,
    output logic         o_in_ready,
    input  logic [N-1:0] i_in_x,
    input  logic [N-1:0] i_in_y,
    output logic         o_out_valid,
    input  logic         i_out_ready,
    output logic [N-1:0] o_out_q,
    output logic         o_out_dz,
    output logic         o_out_ovf,
    output logic         o_busy
);

    localparam int              CW         = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0]   C_CNT_LOAD = CW'(SETTLE_CYCLES - 1);

    div_state_t     r_state;
    div_state_t     w_state_nxt;
    logic [N-1:0]   r_x;
    logic [N-1:0]   r_y;
    logic [CW-1:0]  r_cnt;
    logic [N-1:0]   r_q;
    div_flags_t     r_flags;
    logic [N-1:0]   w_core_q;
    div_flags_t     w_flags;
    logic [N-1:0]   w_special_q;
    logic           w_special;

    intdiv_intdiv #(
        .N (N)
    ) u_core (
        .i_x (r_x),
        .i_y (r_y),
        .o_q (w_core_q)
    );

    // Detection looks at the operands being latched so the fast path lands in DONE one cycle later.
`ifdef INTDIV_SPECIAL_EN
    localparam logic [N-1:0] C_MOST_NEG = N'(most_neg(N));

    always_comb begin
        w_flags.dz  = (i_in_y == '0);
        w_flags.ovf = !w_flags.dz && (i_in_x == C_MOST_NEG) && (i_in_y == '1);
        w_special_q = w_flags.ovf ? C_MOST_NEG : '0;
    end
`else
    assign w_flags     = '0;
    assign w_special_q = '0;
`endif

    assign w_special = w_flags.dz | w_flags.ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (i_flush) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:   if (i_in_valid) w_state_nxt = w_special ? ST_DONE : ST_SETTLE;
                ST_SETTLE: if (r_cnt == '0) w_state_nxt = ST_DONE;
                ST_DONE:   if (i_out_ready) w_state_nxt = ST_IDLE;
                default:   w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        o_in_ready  = (r_state == ST_IDLE) && !i_flush;
        o_out_valid = (r_state == ST_DONE);
        o_busy      = (r_state != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x     <= '0;
            r_y     <= '0;
            r_cnt   <= '0;
            r_q     <= '0;
            r_flags <= '0;
        end else if (i_flush) begin
            r_cnt   <= '0;
            r_q     <= '0;
            r_flags <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_in_valid) begin
                        r_x   <= i_in_x;
                        r_y   <= i_in_y;
                        r_cnt <= C_CNT_LOAD;
                        if (w_special) begin
                            r_q     <= w_special_q;
                            r_flags <= w_flags;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (r_cnt == '0) begin
                        r_q     <= w_core_q;
                        r_flags <= '0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_out_q   = r_q;
    assign o_out_dz  = r_flags.dz;
    assign o_out_ovf = r_flags.ovf;

endmodule

`default_nettype wire

// File: tb/tb_intdiv_seq_ctrl.sv
// ============================================================================
// Module      : tb_intdiv_seq_ctrl
// Description : Scoreboard bench for intdiv_seq_ctrl (honours INTDIV_SPECIAL_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_intdiv_seq_ctrl;

    localparam int N = 5;
    localparam int S = 2;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         flush     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b0;
    logic [N-1:0] in_x      = '0;
    logic [N-1:0] in_y      = '0;
    logic         in_ready;
    logic         out_valid;
    logic [N-1:0] out_q;
    logic         out_dz;
    logic         out_ovf;
    logic         busy;

    typedef struct {
        logic [N-1:0] q;
        logic         dz;
        logic         ovf;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    intdiv_seq_ctrl #(.N(N), .SETTLE_CYCLES(S)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_flush     (flush),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in_x      (in_x),
        .i_in_y      (in_y),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_q     (out_q),
        .o_out_dz    (out_dz),
        .o_out_ovf   (out_ovf),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [N-1:0] x, input logic [N-1:0] y);
        exp_t e;
        int   xi;
        int   yi;
        int   qi;
        xi    = $signed(x);
        yi    = $signed(y);
        e.dz  = 1'b0;
        e.ovf = 1'b0;
        e.lat = S + 1;
        qi    = (yi == 0) ? 0 : xi / yi;
`ifdef INTDIV_SPECIAL_EN
        if (yi == 0) begin
            e.dz  = 1'b1;
            e.lat = 1;
            qi    = 0;
        end else if (xi == -(1 << (N - 1)) && yi == -1) begin
            e.ovf = 1'b1;
            e.lat = 1;
        end
`endif
        e.q = qi[N-1:0];
        return e;
    endfunction

    // Drives one accepted handshake; returns just after the accepting edge.
    task automatic issue(input logic [N-1:0] x, input logic [N-1:0] y);
        @(negedge clk);
        in_valid = 1'b1;
        in_x     = x;
        in_y     = y;
        sb.push_back(model(x, y));
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!out_valid && cyc < 40);
    endtask

    task automatic consume;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (out_q !== '0)       begin errors++; $display("FAIL reset_out_q got %b want 0", out_q); end
        checks++; if (out_dz !== 1'b0 || out_ovf !== 1'b0) begin errors++; $display("FAIL reset_flags got dz=%b ovf=%b want 0 0", out_dz, out_ovf); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    endtask

    task automatic test_basic;
        logic [N-1:0] xs [5] = '{5'd7, 5'b11001, 5'd7, 5'b11111, 5'd15};
        logic [N-1:0] ys [5] = '{5'd3, 5'd2, 5'b11110, 5'd5, 5'd1};
        exp_t e;
        int   cyc;
        for (int i = 0; i < 5; i++) begin
            issue(xs[i], ys[i]);
            wait_valid(cyc);
            e = sb.pop_front();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_timeout[%0d] got out_valid=%b want 1", i, out_valid); end
            checks++; if (cyc !== e.lat) begin errors++; $display("FAIL basic_latency[%0d] got %0d want %0d", i, cyc, e.lat); end
            checks++; if ({out_q, out_dz, out_ovf} !== {e.q, e.dz, e.ovf}) begin
                errors++; $display("FAIL basic_result[%0d] got q=%b dz=%b ovf=%b want q=%b dz=%b ovf=%b", i, out_q, out_dz, out_ovf, e.q, e.dz, e.ovf);
            end
            consume();
            checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL basic_return[%0d] got valid=%b ready=%b want 0 1", i, out_valid, in_ready); end
        end
    endtask

    task automatic test_special;
`ifdef INTDIV_SPECIAL_EN
        logic [N-1:0] xs [3] = '{5'd9, 5'b10000, 5'b10000};
        logic [N-1:0] ys [3] = '{5'd0, 5'b11111, 5'd0};
        localparam int NS = 3;
`else
        logic [N-1:0] xs [1] = '{5'b10000};
        logic [N-1:0] ys [1] = '{5'b11111};
        localparam int NS = 1;
`endif
        exp_t e;
        int   cyc;
        for (int i = 0; i < NS; i++) begin
            issue(xs[i], ys[i]);
            wait_valid(cyc);
            e = sb.pop_front();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL special_timeout[%0d] got out_valid=%b want 1", i, out_valid); end
            checks++; if (cyc !== e.lat) begin errors++; $display("FAIL special_latency[%0d] got %0d want %0d", i, cyc, e.lat); end
            checks++; if ({out_q, out_dz, out_ovf} !== {e.q, e.dz, e.ovf}) begin
                errors++; $display("FAIL special_result[%0d] got q=%b dz=%b ovf=%b want q=%b dz=%b ovf=%b", i, out_q, out_dz, out_ovf, e.q, e.dz, e.ovf);
            end
            consume();
        end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        int   t;
        int   cyc;
        int   seen = 0;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_x      = 5'd8;
        in_y      = 5'd2;
        sb.push_back(model(5'd8, 5'd2));
        @(posedge clk);
        #1;
        in_x = 5'b11000;
        in_y = 5'd3;
        sb.push_back(model(5'b11000, 5'd3));
        t = 0;
        do begin
            @(negedge clk);
            t++;
            if (out_valid) begin
                seen++;
                e = sb.pop_front();
                checks++; if (out_q !== e.q) begin errors++; $display("FAIL b2b_first_q got %b want %b", out_q, e.q); end
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_in_done got %b want 0", in_ready); end
            end
        end while (!in_ready && t < 40);
        checks++; if (t !== S + 2) begin errors++; $display("FAIL b2b_period got %0d want %0d", t, S + 2); end
        checks++; if (seen !== 1) begin errors++; $display("FAIL b2b_first_seen got %0d want 1", seen); end
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_valid(cyc);
        e = sb.pop_front();
        checks++; if (out_valid !== 1'b1 || cyc !== e.lat) begin errors++; $display("FAIL b2b_second_latency got valid=%b cyc=%0d want 1 %0d", out_valid, cyc, e.lat); end
        checks++; if (out_q !== e.q) begin errors++; $display("FAIL b2b_second_q got %b want %b", out_q, e.q); end
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got out_valid=%b want 0", out_valid); end
    endtask

    task automatic test_backpressure;
        exp_t e;
        int   cyc;
        issue(5'd10, 5'd3);
        wait_valid(cyc);
        e = sb.pop_front();
        checks++; if (out_valid !== 1'b1 || out_q !== e.q) begin errors++; $display("FAIL bp_result got valid=%b q=%b want 1 %b", out_valid, out_q, e.q); end
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_x     = 5'd1;
            in_y     = 5'd1;
            @(negedge clk);
            checks++; if (out_valid !== 1'b1 || out_q !== e.q || in_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold[%0d] got valid=%b q=%b ready=%b want 1 %b 0", i, out_valid, out_q, in_ready, e.q);
            end
        end
        in_valid = 1'b0;
        consume();
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release got valid=%b busy=%b ready=%b want 0 0 1", out_valid, busy, in_ready);
        end
    endtask

    task automatic test_flush;
        int rises = 0;
        issue(5'd7, 5'd2);
        void'(sb.pop_back());
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_pre_busy got %b want 1", busy); end
        flush    = 1'b1;
        in_valid = 1'b1;
        in_x     = 5'd3;
        in_y     = 5'd1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b want 0", in_ready); end
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_idle got busy=%b valid=%b ready=%b want 0 0 1", busy, out_valid, in_ready);
        end
        checks++; if (out_q !== '0) begin errors++; $display("FAIL flush_out_q got %b want 0", out_q); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid || busy) rises++;
        end
        checks++; if (rises !== 0) begin errors++; $display("FAIL flush_quiet got %0d active cycles want 0", rises); end
    endtask

    task automatic test_reset_mid;
        exp_t e;
        int   cyc;
        issue(5'd5, 5'd1);
        wait_valid(cyc);
        e = sb.pop_front();
        checks++; if (out_q !== e.q) begin errors++; $display("FAIL rst_pre_q got %b want %b", out_q, e.q); end
        consume();
        issue(5'd6, 5'd2);
        void'(sb.pop_back());
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL rst_mid_ctrl got busy=%b valid=%b ready=%b want 0 0 1", busy, out_valid, in_ready);
        end
        checks++; if (out_q !== '0 || out_dz !== 1'b0 || out_ovf !== 1'b0) begin
            errors++; $display("FAIL rst_mid_out got q=%b dz=%b ovf=%b want 0 0 0", out_q, out_dz, out_ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        issue(5'd7, 5'd1);
        wait_valid(cyc);
        e = sb.pop_front();
        checks++; if (out_valid !== 1'b1 || out_q !== 5'd7) begin errors++; $display("FAIL rst_after_q got valid=%b q=%b want 1 00111", out_valid, out_q); end
        consume();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic();
        test_special();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_mid();
        checks++; if (sb.size() !== 0) begin errors++; $display("FAIL scoreboard_leftover got %0d want 0", sb.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
